// File: rtl/sink_rand_pkg.sv
// Shared types and constants for the randomly stalling stream sink and its LFSR.
// Kept separate so source-side models can reuse the same LFSR definition.
package sink_rand_pkg;

    typedef enum logic {
        ACCEPT = 1'b0,
        STALL  = 1'b1
    } state_t;

    localparam int LFSR_W      = 16;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int BEAT_CNT_W  = 32;
    localparam int PKT_CNT_W   = 16;
    localparam int PKT_LEN_W   = 16;
    localparam int STALL_CNT_W = 3;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances on every clock edge outside reset.
// The seed is loaded asynchronously while rst is high and must be nonzero.
module lfsr16
    import sink_rand_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= seed;
        end else begin
            r_value <= lfsr_next(r_value);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/sink_rand.sv
// Stream sink that accepts beats, inserts pseudo-random back-pressure after
// transfers, and reports per-packet length/sum plus global beat/packet counts.
module sink_rand
    import sink_rand_pkg::*;
#(
    parameter int          LEN      = 8,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter bit          STALL_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  last,
    input  logic [LEN-1:0]        data,
    output logic                  ready,
    output logic                  pkt_done,
    output logic [PKT_LEN_W-1:0]  pkt_len,
    output logic [LEN+7:0]        pkt_sum,
    output logic [BEAT_CNT_W-1:0] beat_cnt,
    output logic [PKT_CNT_W-1:0]  pkt_cnt,
    output logic [LEN-1:0]        last_data,
    output state_t                dbg_state
);

    // Handshake: a beat moves on a rising edge where valid and ready are both
    // high; valid seen while ready is low is ignored and data is not sampled.

    logic [LFSR_W-1:0]      w_lfsr;
    logic                   w_xfer;
    logic [STALL_CNT_W-1:0] w_stall_len;
    state_t                 w_state_next;
    logic [STALL_CNT_W-1:0] w_stall_next;
    logic [PKT_LEN_W-1:0]   w_len_inc;
    logic [LEN+7:0]         w_sum_inc;

    state_t                 r_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   r_ready;
    logic                   r_pkt_done;
    logic [PKT_LEN_W-1:0]   r_pkt_len;
    logic [LEN+7:0]         r_pkt_sum;
    logic [BEAT_CNT_W-1:0]  r_beat_cnt;
    logic [PKT_CNT_W-1:0]   r_pkt_cnt;
    logic [LEN-1:0]         r_last_data;
    logic [PKT_LEN_W-1:0]   r_run_len;
    logic [LEN+7:0]         r_run_sum;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .seed  (SEED),
        .value (w_lfsr)
    );

    assign w_xfer      = valid & r_ready;
    assign w_stall_len = w_lfsr[STALL_CNT_W-1:0];

    // Stall counter holds the remaining low-ready cycles, including the current one.
    always_comb begin
        w_state_next = r_state;
        w_stall_next = r_stall_cnt;
        case (r_state)
            ACCEPT: begin
                if (w_xfer && STALL_EN && (w_stall_len != '0)) begin
                    w_state_next = STALL;
                    w_stall_next = w_stall_len;
                end
            end
            STALL: begin
                if (r_stall_cnt <= STALL_CNT_W'(1)) begin
                    w_state_next = ACCEPT;
                    w_stall_next = '0;
                end else begin
                    w_stall_next = r_stall_cnt - STALL_CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ACCEPT;
            r_stall_cnt <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_stall_cnt <= w_stall_next;
            r_ready     <= (w_state_next == ACCEPT);
        end
    end

    // Running length saturates; the sum wraps at LEN+8 bits.
    assign w_len_inc = (r_run_len == '1) ? r_run_len : r_run_len + PKT_LEN_W'(1);
    assign w_sum_inc = r_run_sum + {8'h00, data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_done  <= 1'b0;
            r_pkt_len   <= '0;
            r_pkt_sum   <= '0;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_last_data <= '0;
            r_run_len   <= '0;
            r_run_sum   <= '0;
        end else begin
            r_pkt_done <= 1'b0;
            if (w_xfer) begin
                r_beat_cnt  <= r_beat_cnt + BEAT_CNT_W'(1);
                r_last_data <= data;
                if (last) begin
                    r_pkt_len  <= w_len_inc;
                    r_pkt_sum  <= w_sum_inc;
                    r_pkt_done <= 1'b1;
                    r_pkt_cnt  <= r_pkt_cnt + PKT_CNT_W'(1);
                    r_run_len  <= '0;
                    r_run_sum  <= '0;
                end else begin
                    r_run_len  <= w_len_inc;
                    r_run_sum  <= w_sum_inc;
                end
            end
        end
    end

    assign ready     = r_ready;
    assign pkt_done  = r_pkt_done;
    assign pkt_len   = r_pkt_len;
    assign pkt_sum   = r_pkt_sum;
    assign beat_cnt  = r_beat_cnt;
    assign pkt_cnt   = r_pkt_cnt;
    assign last_data = r_last_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sink_rand.sv
// Directed bench for sink_rand: one instance without stalls for packet
// arithmetic, one with stalls checked against an independent LFSR model.
module tb_sink_rand;
    import sink_rand_pkg::*;

    logic clk;
    logic rst;

    logic        ns_valid, ns_last;
    logic [7:0]  ns_data;
    logic        ns_ready, ns_done;
    logic [15:0] ns_len, ns_sum, ns_pcnt;
    logic [31:0] ns_bcnt;
    logic [7:0]  ns_ldata;
    state_t      ns_dbg;

    logic        st_valid, st_last;
    logic [7:0]  st_data;
    logic        st_ready, st_done;
    logic [15:0] st_len, st_sum, st_pcnt;
    logic [31:0] st_bcnt;
    logic [7:0]  st_ldata;
    state_t      st_dbg;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] m_lfsr;
    logic [2:0]  exp_q[$];

    sink_rand #(.LEN(8), .SEED(16'hACE1), .STALL_EN(1'b0)) u_dut_ns (
        .clk(clk), .rst(rst), .valid(ns_valid), .last(ns_last), .data(ns_data),
        .ready(ns_ready), .pkt_done(ns_done), .pkt_len(ns_len), .pkt_sum(ns_sum),
        .beat_cnt(ns_bcnt), .pkt_cnt(ns_pcnt), .last_data(ns_ldata), .dbg_state(ns_dbg)
    );

    sink_rand #(.LEN(8), .SEED(16'hACE1), .STALL_EN(1'b1)) u_dut_st (
        .clk(clk), .rst(rst), .valid(st_valid), .last(st_last), .data(st_data),
        .ready(st_ready), .pkt_done(st_done), .pkt_len(st_len), .pkt_sum(st_sum),
        .beat_cnt(st_bcnt), .pkt_cnt(st_pcnt), .last_data(st_ldata), .dbg_state(st_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, shifting toward the MSB.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: present a beat to the no-stall sink, return at the next falling edge.
    task automatic ns_drive(input logic [7:0] d, input logic l, input logic v);
        ns_data  = d;
        ns_last  = l;
        ns_valid = v;
        @(negedge clk);
    endtask

    task automatic ns_pkt_check(input string tag, input logic done, input logic [15:0] len,
                                input logic [15:0] sum, input logic [15:0] pcnt);
        check({tag, "_done"}, 32'(ns_done), 32'(done));
        check({tag, "_len"},  32'(ns_len),  32'(len));
        check({tag, "_sum"},  32'(ns_sum),  32'(sum));
        check({tag, "_pcnt"}, 32'(ns_pcnt), 32'(pcnt));
    endtask

    initial begin
        logic       m_ready;
        int         m_stall;
        int         m_beats;
        logic [7:0] m_last;
        logic [7:0] cur;
        int         cur_low;
        logic [2:0] n;

        rst = 1'b1;
        ns_valid = 1'b1; ns_last = 1'b0; ns_data = 8'hA5;
        st_valid = 1'b1; st_last = 1'b0; st_data = 8'h5A;

        // reset held three cycles with valid high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_ns", 32'(ns_ready), 32'd0);
        check("rst_ready_st", 32'(st_ready), 32'd0);
        check("rst_bcnt",     ns_bcnt,       32'd0);
        check("rst_done",     32'(ns_done),  32'd0);
        check("rst_len",      32'(ns_len),   32'd0);
        check("rst_ldata",    32'(ns_ldata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready_ns", 32'(ns_ready), 32'd1);
        check("rel_ready_st", 32'(st_ready), 32'd1);
        check("rel_bcnt_st",  st_bcnt,       32'd0);
        check("rel_bcnt_ns",  ns_bcnt,       32'd0);
        ns_valid = 1'b0;
        st_valid = 1'b0;

        // single-beat packet
        ns_drive(8'hFF, 1'b1, 1'b1);
        ns_pkt_check("single", 1'b1, 16'd1, 16'h00FF, 16'd1);
        check("single_ldata", 32'(ns_ldata), 32'hFF);
        ns_drive(8'h00, 1'b0, 1'b0);
        ns_pkt_check("single_hold", 1'b0, 16'd1, 16'h00FF, 16'd1);

        // last without valid does nothing
        ns_drive(8'h99, 1'b1, 1'b0);
        ns_pkt_check("nolast", 1'b0, 16'd1, 16'h00FF, 16'd1);
        check("nolast_bcnt",  ns_bcnt,       32'd1);
        check("nolast_ldata", 32'(ns_ldata), 32'hFF);

        // four-beat continuous packet
        ns_drive(8'h10, 1'b0, 1'b1);
        check("p4_ready1", 32'(ns_ready), 32'd1);
        ns_drive(8'h20, 1'b0, 1'b1);
        check("p4_ready2", 32'(ns_ready), 32'd1);
        ns_drive(8'h30, 1'b0, 1'b1);
        check("p4_ready3", 32'(ns_ready), 32'd1);
        check("p4_early",  32'(ns_done),  32'd0);
        check("p4_bcnt3",  ns_bcnt,       32'd4);
        ns_drive(8'h40, 1'b1, 1'b1);
        ns_pkt_check("p4", 1'b1, 16'd4, 16'h00A0, 16'd2);
        check("p4_bcnt",  ns_bcnt,       32'd5);
        check("p4_ldata", 32'(ns_ldata), 32'h40);

        // back-to-back packets
        ns_drive(8'h05, 1'b1, 1'b1);
        ns_pkt_check("b2b1", 1'b1, 16'd1, 16'h0005, 16'd3);
        ns_drive(8'h06, 1'b0, 1'b1);
        ns_pkt_check("b2b_mid", 1'b0, 16'd1, 16'h0005, 16'd3);
        ns_drive(8'h07, 1'b1, 1'b1);
        ns_pkt_check("b2b2", 1'b1, 16'd2, 16'h000D, 16'd4);

        // sum wider than the data path
        ns_drive(8'hFF, 1'b0, 1'b1);
        ns_drive(8'hFF, 1'b1, 1'b1);
        ns_pkt_check("wide", 1'b1, 16'd2, 16'h01FE, 16'd5);
        check("wide_bcnt", ns_bcnt, 32'd10);

        // reset mid-packet discards the partial packet
        ns_drive(8'h11, 1'b0, 1'b1);
        ns_drive(8'h22, 1'b0, 1'b1);
        check("part_done", 32'(ns_done), 32'd0);
        check("part_bcnt", ns_bcnt,      32'd12);
        ns_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ns_pkt_check("mid_rst", 1'b0, 16'd0, 16'h0000, 16'd0);
        check("mid_rst_bcnt",  ns_bcnt,       32'd0);
        check("mid_rst_ready", 32'(ns_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", 32'(ns_done), 32'd0);
        ns_drive(8'h03, 1'b1, 1'b1);
        ns_pkt_check("post_rst", 1'b1, 16'd1, 16'h0003, 16'd1);
        ns_valid = 1'b0;

        // stalling sink with valid held high; data advances only on a transfer
        m_ready = 1'b1;
        m_stall = 0;
        m_beats = 0;
        m_last  = 8'h00;
        cur     = 8'h01;
        cur_low = 0;
        for (int i = 0; i < 50; i++) begin
            check("st_ready", 32'(st_ready), 32'(m_ready));
            check("st_state", 32'(st_dbg),   m_ready ? 32'(ACCEPT) : 32'(STALL));
            check("st_ldata", 32'(st_ldata), 32'(m_last));
            if (!st_ready) begin
                cur_low++;
            end else if (cur_low > 0) begin
                if (exp_q.size() == 0) begin
                    check("st_run_unexpected", 32'(cur_low), 32'd0);
                end else begin
                    check("st_run_len", 32'(cur_low), 32'(exp_q.pop_front()));
                end
                cur_low = 0;
            end
            st_valid = 1'b1;
            st_last  = 1'b0;
            st_data  = cur;
            if (m_ready) begin
                m_beats++;
                m_last = cur;
                cur    = cur + 8'd1;
                n      = m_lfsr[2:0];
                if (n != 3'd0) begin
                    m_ready = 1'b0;
                    m_stall = int'(n);
                    exp_q.push_back(n);
                end
            end else begin
                m_stall--;
                if (m_stall == 0) m_ready = 1'b1;
            end
            @(negedge clk);
        end
        st_valid = 1'b0;
        check("st_bcnt",  st_bcnt,       32'(m_beats));
        check("st_ldata_end", 32'(st_ldata), 32'(m_last));
        check("st_no_pkt", 32'(st_pcnt),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
